bool_sweep_checker: RTL and testbench

Self-checking exhaustive stimulus engine for combinational boolean blocks with N inputs and a single output. On `start` it drives every input vector from 0 to 2^N_IN-1 onto the device under test, waits a programmable settle time, samples the DUT output, and compares it against a truth table supplied as a parameter. It reports a mismatch count, the first failing vector and a pass/done flag. It replaces hand-written `{a,b,c}` sweep sequences in boolean testbenches and can also be instantiated on-chip as a built-in self-test wrapper.

---
 rtl/bool_sweep_checker_if.sv | 28 ++
 rtl/bool_sweep_checker.sv | 182 ++++++++++++++++++
 tb/tb_bool_sweep_checker.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bool_sweep_checker_if.sv
// Control/result bundle of bool_sweep_checker: sweep handshake, DUT drive/response
// and result reporting. The controller side is the master, the checker the slave.
interface bool_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int ERR_W = 8
);
  logic                   start;
  logic                   abort;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [ERR_W-1:0]       err_cnt;
  logic [N_IN-1:0]        first_err_vec;
  logic                   first_err_vld;
  logic [(1<<N_IN)-1:0]   resp;

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, err_cnt, first_err_vec, first_err_vld, resp
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, err_cnt, first_err_vec, first_err_vld, resp
  );
endinterface

// File: rtl/bool_sweep_checker.sv
// Exhaustive stimulus/compare engine for an N_IN-input boolean block.
// Define BOOL_SWEEP_CAPTURE_EN to build the per-vector response capture table.
module bool_sweep_checker #(
  parameter int                   N_IN   = 3,
  parameter int                   SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT = '0,
  parameter int                   ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bool_sweep_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]       SETTLE_L   = 8'(SETTLE);
  localparam logic [N_IN-1:0]  LAST_VEC   = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  // With no settle time every vector goes straight to its compare cycle.
  localparam state_t           LOAD_STATE = (SETTLE_L == 8'd0) ? S_SAMPLE : S_WAIT;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic [7:0]       wait_q, wait_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]  first_err_vec_q, first_err_vec_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch_s;

`ifdef BOOL_SWEEP_CAPTURE_EN
  logic [(1<<N_IN)-1:0] resp_q, resp_d;
`endif

  assign mismatch_s = (bus.dut_out != EXPECT[vec_q]);

  // Next-state and datapath; abort overrides everything and freezes partial results.
  always_comb begin
    state_d         = state_q;
    vec_d           = vec_q;
    dut_in_d        = dut_in_q;
    wait_d          = wait_q;
    err_cnt_d       = err_cnt_q;
    first_err_vec_d = first_err_vec_q;
    first_err_vld_d = first_err_vld_q;
`ifdef BOOL_SWEEP_CAPTURE_EN
    resp_d          = resp_q;
`endif

    if (bus.abort) begin
      state_d  = S_IDLE;
      vec_d    = '0;
      dut_in_d = '0;
      wait_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d         = LOAD_STATE;
            vec_d           = '0;
            dut_in_d        = '0;
            wait_d          = SETTLE_L;
            err_cnt_d       = '0;
            first_err_vec_d = '0;
            first_err_vld_d = 1'b0;
`ifdef BOOL_SWEEP_CAPTURE_EN
            resp_d          = '0;
`endif
          end else begin
            state_d = state_q;
          end
        end
        S_WAIT: begin
          wait_d = wait_q - 8'd1;
          if (wait_q <= 8'd1) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_SAMPLE: begin
          if (mismatch_s) begin
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
            if (!first_err_vld_q) begin
              first_err_vec_d = vec_q;
              first_err_vld_d = 1'b1;
            end else begin
              first_err_vec_d = first_err_vec_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
`ifdef BOOL_SWEEP_CAPTURE_EN
          resp_d[vec_q] = bus.dut_out;
`endif
          if (vec_q == LAST_VEC) begin
            state_d = S_DONE;
          end else begin
            vec_d    = vec_q + N_IN'(1);
            dut_in_d = vec_q + N_IN'(1);
            wait_d   = SETTLE_L;
            state_d  = LOAD_STATE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          vec_d    = '0;
          dut_in_d = '0;
          wait_d   = 8'd0;
        end
      endcase
    end

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == S_WAIT) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      vec_q           <= '0;
      dut_in_q        <= '0;
      wait_q          <= 8'd0;
      err_cnt_q       <= '0;
      first_err_vec_q <= '0;
      first_err_vld_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      dut_in_q        <= dut_in_d;
      wait_q          <= wait_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_vld_q <= first_err_vld_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

`ifdef BOOL_SWEEP_CAPTURE_EN
  // Response capture table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign bus.resp = resp_q;
`else
  assign bus.resp = '0;
`endif

  assign bus.dut_in        = dut_in_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Bench for bool_sweep_checker: a 3-input majority target (with injectable faults)
// and a 4-input stuck-at-0 target checked against a behavioural scoreboard.
module tb_bool_sweep_checker;

  localparam logic [7:0] MAJ_TT = 8'b1110_1000;

  typedef struct {
    logic [7:0] err;
    logic [2:0] fvec;
    logic       fvld;
    logic       pass;
    logic [7:0] resp;
  } res0_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fault_mask = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;
  res0_t      res0_q[$];
  int         din_q[$];

  bool_sweep_checker_if #(.N_IN(3), .ERR_W(8)) bus0();
  bool_sweep_checker_if #(.N_IN(4), .ERR_W(3)) bus1();

  bool_sweep_checker #(.N_IN(3), .SETTLE(1), .EXPECT(MAJ_TT), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  bool_sweep_checker #(.N_IN(4), .SETTLE(0), .EXPECT(16'hFFFF), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  function automatic logic maj3(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  assign bus0.dut_out = maj3(bus0.dut_in) ^ fault_mask[bus0.dut_in];
  assign bus1.dut_out = 1'b0;

  // Reference results for the majority target after its first nvec compares.
  function automatic res0_t model0(input logic [7:0] fm, input int nvec);
    res0_t r;
    logic  o;
    logic [2:0] k3;
    r.err = 8'd0; r.fvec = 3'd0; r.fvld = 1'b0; r.resp = 8'd0;
    for (int k = 0; k < nvec; k++) begin
      k3 = 3'(k);
      o  = maj3(k3) ^ fm[k];
      if (o != MAJ_TT[k]) begin
        r.err = r.err + 8'd1;
        if (!r.fvld) begin r.fvec = k3; r.fvld = 1'b1; end
      end
`ifdef BOOL_SWEEP_CAPTURE_EN
      r.resp[k] = o;
`endif
    end
    r.pass = (nvec == 8) && (r.err == 8'd0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep0(input logic [7:0] fm);
    for (int e = 0; e < 16; e++) din_q.push_back(e / 2);
    res0_q.push_back(model0(fm, 8));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    tick(); tick();
    n_vec++;
    if ({bus0.busy, bus0.done, bus0.pass, bus0.first_err_vld} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {bus0.busy, bus0.done, bus0.pass, bus0.first_err_vld});
    end
    n_vec++;
    if ({bus0.dut_in, bus0.err_cnt, bus0.first_err_vec, bus0.resp} !== 22'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {bus0.dut_in, bus0.err_cnt, bus0.first_err_vec, bus0.resp});
    end
    n_vec++;
    if ({bus1.busy, bus1.done, bus1.dut_in, bus1.err_cnt, bus1.resp} !== 25'd0) begin
      n_err++; $display("FAIL reset_dut1: got %h want 0", {bus1.busy, bus1.done, bus1.dut_in, bus1.err_cnt, bus1.resp});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_majority_pass();
    res0_t ex;
    int    d;
    fault_mask = 8'h00;
    push_sweep0(fault_mask);
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int e = 0; e < 16; e++) begin
      d = din_q.pop_front();
      n_vec++;
      if (bus0.dut_in !== 3'(d) || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
        n_err++; $display("FAIL maj_step e=%0d: got din=%0d busy=%b done=%b want din=%0d busy=1 done=0", e, bus0.dut_in, bus0.busy, bus0.done, d);
      end
      if (e < 15) tick();
    end
    tick();
    ex = res0_q.pop_front();
    n_vec++;
    if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.pass !== ex.pass) begin
      n_err++; $display("FAIL maj_done: got done=%b busy=%b pass=%b want 1 0 %b", bus0.done, bus0.busy, bus0.pass, ex.pass);
    end
    n_vec++;
    if (bus0.err_cnt !== ex.err || bus0.first_err_vld !== ex.fvld || bus0.resp !== ex.resp || bus0.dut_in !== 3'd7) begin
      n_err++; $display("FAIL maj_result: got err=%0d vld=%b resp=%b din=%0d want %0d %b %b 7", bus0.err_cnt, bus0.first_err_vld, bus0.resp, bus0.dut_in, ex.err, ex.fvld, ex.resp);
    end
  endtask

  // Faults on vectors 5 and 6, then an immediate restart from DONE with a clean target.
  task automatic test_back_to_back();
    res0_t ex;
    fault_mask = 8'b0110_0000;
    res0_q.push_back(model0(fault_mask, 8));
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int e = 1; e < 16; e++) tick();
    n_vec++;
    if (bus0.done !== 1'b0) begin
      n_err++; $display("FAIL fault_early_done: got %b want 0", bus0.done);
    end
    tick();
    ex = res0_q.pop_front();
    n_vec++;
    if (bus0.done !== 1'b1 || bus0.pass !== ex.pass || bus0.err_cnt !== ex.err) begin
      n_err++; $display("FAIL fault_done: got done=%b pass=%b err=%0d want 1 %b %0d", bus0.done, bus0.pass, bus0.err_cnt, ex.pass, ex.err);
    end
    n_vec++;
    if (bus0.first_err_vec !== ex.fvec || bus0.first_err_vld !== ex.fvld || bus0.resp !== ex.resp) begin
      n_err++; $display("FAIL fault_first: got vec=%0d vld=%b resp=%b want %0d %b %b", bus0.first_err_vec, bus0.first_err_vld, bus0.resp, ex.fvec, ex.fvld, ex.resp);
    end
    fault_mask = 8'h00;
    res0_q.push_back(model0(fault_mask, 8));
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    n_vec++;
    if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.err_cnt !== 8'd0 || bus0.first_err_vld !== 1'b0 || bus0.resp !== 8'd0) begin
      n_err++; $display("FAIL b2b_restart: got busy=%b done=%b err=%0d vld=%b resp=%b want 1 0 0 0 0", bus0.busy, bus0.done, bus0.err_cnt, bus0.first_err_vld, bus0.resp);
    end
    for (int e = 1; e < 17; e++) tick();
    ex = res0_q.pop_front();
    n_vec++;
    if (bus0.done !== 1'b1 || bus0.pass !== ex.pass || bus0.err_cnt !== ex.err || bus0.resp !== ex.resp) begin
      n_err++; $display("FAIL b2b_done: got done=%b pass=%b err=%0d resp=%b want 1 %b %0d %b", bus0.done, bus0.pass, bus0.err_cnt, bus0.resp, ex.pass, ex.err, ex.resp);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_resp;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    for (int e = 0; e < 16; e++) begin
      n_vec++;
      if (bus1.dut_in !== 4'(e) || bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
        n_err++; $display("FAIL sat_step e=%0d: got din=%0d busy=%b done=%b want din=%0d busy=1 done=0", e, bus1.dut_in, bus1.busy, bus1.done, e);
      end
      tick();
    end
    exp_resp = 16'h0000;
    n_vec++;
    if (bus1.done !== 1'b1 || bus1.pass !== 1'b0 || bus1.err_cnt !== 3'd7) begin
      n_err++; $display("FAIL sat_done: got done=%b pass=%b err=%0d want 1 0 7", bus1.done, bus1.pass, bus1.err_cnt);
    end
    n_vec++;
    if (bus1.first_err_vec !== 4'd0 || bus1.first_err_vld !== 1'b1 || bus1.resp !== exp_resp) begin
      n_err++; $display("FAIL sat_first: got vec=%0d vld=%b resp=%h want 0 1 %h", bus1.first_err_vec, bus1.first_err_vld, bus1.resp, exp_resp);
    end
  endtask

  task automatic test_abort();
    res0_t ex;
    fault_mask = 8'b0000_0110;
    ex = model0(fault_mask, 3);
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int e = 1; e < 8; e++) tick();
    n_vec++;
    if (bus0.dut_in !== 3'd3 || bus0.busy !== 1'b1) begin
      n_err++; $display("FAIL abort_pre: got din=%0d busy=%b want 3 1", bus0.dut_in, bus0.busy);
    end
    bus0.abort = 1'b1; tick(); bus0.abort = 1'b0;
    n_vec++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0 || bus0.dut_in !== 3'd0) begin
      n_err++; $display("FAIL abort_idle: got busy=%b done=%b pass=%b din=%0d want 0 0 0 0", bus0.busy, bus0.done, bus0.pass, bus0.dut_in);
    end
    n_vec++;
    if (bus0.err_cnt !== ex.err || bus0.first_err_vec !== ex.fvec || bus0.first_err_vld !== ex.fvld || bus0.resp !== ex.resp) begin
      n_err++; $display("FAIL abort_hold: got err=%0d vec=%0d vld=%b resp=%b want %0d %0d %b %b", bus0.err_cnt, bus0.first_err_vec, bus0.first_err_vld, bus0.resp, ex.err, ex.fvec, ex.fvld, ex.resp);
    end
    tick();
    n_vec++;
    if (bus0.busy !== 1'b0 || bus0.err_cnt !== ex.err) begin
      n_err++; $display("FAIL abort_stay: got busy=%b err=%0d want 0 %0d", bus0.busy, bus0.err_cnt, ex.err);
    end
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    n_vec++;
    if (bus0.busy !== 1'b1 || bus0.dut_in !== 3'd0 || bus0.err_cnt !== 8'd0 || bus0.first_err_vld !== 1'b0 || bus0.resp !== 8'd0) begin
      n_err++; $display("FAIL abort_restart: got busy=%b din=%0d err=%0d vld=%b resp=%b want 1 0 0 0 0", bus0.busy, bus0.dut_in, bus0.err_cnt, bus0.first_err_vld, bus0.resp);
    end
    bus0.abort = 1'b1; tick(); bus0.abort = 1'b0;
    fault_mask = 8'h00;
  endtask

  task automatic test_start_ignored();
    int d;
    fault_mask = 8'h00;
    push_sweep0(fault_mask);
    bus0.start = 1'b1; tick();
    void'(din_q.pop_front());
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int e = 1; e < 16; e++) begin
      d = din_q.pop_front();
      n_vec++;
      if (bus0.dut_in !== 3'(d) || bus0.busy !== 1'b1) begin
        n_err++; $display("FAIL ign_step e=%0d: got din=%0d busy=%b want din=%0d busy=1", e, bus0.dut_in, bus0.busy, d);
      end
      if (e < 15) tick();
    end
    tick();
    void'(res0_q.pop_front());
    n_vec++;
    if (bus0.done !== 1'b1 || bus0.pass !== 1'b1) begin
      n_err++; $display("FAIL ign_done: got done=%b pass=%b want 1 1", bus0.done, bus0.pass);
    end
    bus0.start = 1'b1; bus0.abort = 1'b1; tick();
    n_vec++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0) begin
      n_err++; $display("FAIL sa_from_done: got busy=%b done=%b pass=%b want 0 0 0", bus0.busy, bus0.done, bus0.pass);
    end
    tick(); bus0.start = 1'b0; bus0.abort = 1'b0;
    n_vec++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.dut_in !== 3'd0) begin
      n_err++; $display("FAIL sa_idle: got busy=%b done=%b din=%0d want 0 0 0", bus0.busy, bus0.done, bus0.dut_in);
    end
  endtask

  task automatic test_reset_mid();
    fault_mask = 8'b0000_0010;
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int e = 1; e < 6; e++) tick();
    n_vec++;
    if (bus0.busy !== 1'b1 || bus0.err_cnt !== 8'd1) begin
      n_err++; $display("FAIL rst_pre: got busy=%b err=%0d want 1 1", bus0.busy, bus0.err_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus0.busy, bus0.done, bus0.pass, bus0.first_err_vld, bus0.dut_in, bus0.err_cnt, bus0.first_err_vec, bus0.resp} !== 26'd0) begin
      n_err++; $display("FAIL rst_mid: got %h want 0", {bus0.busy, bus0.done, bus0.pass, bus0.first_err_vld, bus0.dut_in, bus0.err_cnt, bus0.first_err_vec, bus0.resp});
    end
    tick(); rst_n = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if (bus0.busy !== 1'b0 || bus0.dut_in !== 3'd0 || bus0.done !== 1'b0) begin
      n_err++; $display("FAIL rst_no_resume: got busy=%b din=%0d done=%b want 0 0 0", bus0.busy, bus0.dut_in, bus0.done);
    end
    fault_mask = 8'h00;
  endtask

  initial begin
    test_reset();
    test_majority_pass();
    test_back_to_back();
    test_saturate();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
